// File: rtl/release_sink_pkg.sv
// TileLink C/D opcode constants and release sink state encoding, shared with the release initiator.
package release_sink_pkg;

    localparam logic [2:0] TL_C_PROBE_ACK      = 3'd4;
    localparam logic [2:0] TL_C_PROBE_ACK_DATA = 3'd5;
    localparam logic [2:0] TL_C_RELEASE        = 3'd6;
    localparam logic [2:0] TL_C_RELEASE_DATA   = 3'd7;

    localparam logic [2:0] TL_D_GRANT          = 3'd4;
    localparam logic [2:0] TL_D_GRANT_DATA     = 3'd5;
    localparam logic [2:0] TL_D_RELEASE_ACK    = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT1 = 2'd1,
        ST_WB    = 2'd2,
        ST_ACK   = 2'd3
    } sink_state_e;

    // Opcodes 0-3 are not ProbeAck/Release messages and are dropped by the sink.
    function automatic logic c_is_release_msg(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic c_has_data(input logic [2:0] op);
        return op[0];
    endfunction

    function automatic logic c_is_voluntary(input logic [2:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/release_sink.sv
// Collects a 2-beat C-channel ProbeAck/Release into a writeback request, then ReleaseAcks voluntary ones.
// Latency: wb valid the cycle after the last C beat, D valid the cycle after wb fire; wb/D back-pressure stalls with c_ready low.
module release_sink
    import release_sink_pkg::*;
#(
    parameter int SRC_W  = 2,
    parameter int BEAT_W = 256
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  io_c_valid,
    output logic                  io_c_ready,
    input  logic [2:0]            io_c_bits_opcode,
    input  logic [2:0]            io_c_bits_param,
    input  logic [2:0]            io_c_bits_size,
    input  logic [SRC_W-1:0]      io_c_bits_source,
    input  logic [35:0]           io_c_bits_address,
    input  logic                  io_c_bits_echo_blockisdirty,
    input  logic [BEAT_W-1:0]     io_c_bits_data,

    output logic                  io_d_valid,
    input  logic                  io_d_ready,
    output logic [2:0]            io_d_bits_opcode,
    output logic [SRC_W-1:0]      io_d_bits_source,

    output logic                  io_wb_valid,
    input  logic                  io_wb_ready,
    output logic [35:0]           io_wb_bits_addr,
    output logic [2:0]            io_wb_bits_param,
    output logic                  io_wb_bits_hasData,
    output logic                  io_wb_bits_dirty,
    output logic                  io_wb_bits_voluntary,
    output logic [2*BEAT_W-1:0]   io_wb_bits_data
);

    sink_state_e          state_q, state_d;

    logic [SRC_W-1:0]     source_q;
    logic                 voluntary_q;
    logic                 has_data_q;
    logic                 dirty_q;

    logic [35:0]          addr_q;
    logic [2:0]           param_q;
    logic [BEAT_W-1:0]    beat0_q;
    logic [BEAT_W-1:0]    beat1_q;

    logic                 c_fire;
    logic                 take_first;
    logic                 take_second;

    // Size is implied by the fixed 2-beat line and carries no information here.
    logic                 unused_size;
    assign unused_size = ^io_c_bits_size;

    assign io_c_ready  = (state_q == ST_IDLE) || (state_q == ST_BEAT1);
    assign c_fire      = io_c_valid && io_c_ready;
    assign take_first  = c_fire && (state_q == ST_IDLE) && c_is_release_msg(io_c_bits_opcode);
    assign take_second = c_fire && (state_q == ST_BEAT1);

    always_comb begin
        state_d     = state_q;
        io_wb_valid = 1'b0;
        io_d_valid  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (take_first) begin
                    state_d = c_has_data(io_c_bits_opcode) ? ST_BEAT1 : ST_WB;
                end
            end
            ST_BEAT1: begin
                if (io_c_valid) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                io_wb_valid = 1'b1;
                if (io_wb_ready) begin
                    state_d = voluntary_q ? ST_ACK : ST_IDLE;
                end
            end
            ST_ACK: begin
                io_d_valid = 1'b1;
                if (io_d_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            source_q    <= '0;
            voluntary_q <= 1'b0;
            has_data_q  <= 1'b0;
            dirty_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take_first) begin
                source_q    <= io_c_bits_source;
                voluntary_q <= c_is_voluntary(io_c_bits_opcode);
                has_data_q  <= c_has_data(io_c_bits_opcode);
                dirty_q     <= io_c_bits_echo_blockisdirty;
            end
        end
    end

    // Line buffer and request fields are only observed behind has_data_q/state, so they skip reset.
    always_ff @(posedge clock) begin
        if (take_first) begin
            addr_q  <= io_c_bits_address;
            param_q <= io_c_bits_param;
            if (c_has_data(io_c_bits_opcode)) begin
                beat0_q <= io_c_bits_data;
            end
        end
        if (take_second) begin
            beat1_q <= io_c_bits_data;
        end
    end

    assign io_wb_bits_addr      = addr_q;
    assign io_wb_bits_param     = param_q;
    assign io_wb_bits_hasData   = has_data_q;
    assign io_wb_bits_dirty     = dirty_q;
    assign io_wb_bits_voluntary = voluntary_q;
    assign io_wb_bits_data      = has_data_q ? {beat1_q, beat0_q} : '0;

    assign io_d_bits_opcode     = TL_D_RELEASE_ACK;
    assign io_d_bits_source     = source_q;

endmodule

// File: tb/tb_release_sink.sv
// Scoreboard bench for release_sink: directed latency/stall/reset cases plus randomized C traffic.
module tb_release_sink;

    localparam int SRC_W  = 2;
    localparam int BEAT_W = 256;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                 reset = 1'b1;
    logic                 io_c_valid = 1'b0;
    logic                 io_c_ready;
    logic [2:0]           io_c_bits_opcode = '0;
    logic [2:0]           io_c_bits_param = '0;
    logic [2:0]           io_c_bits_size = '0;
    logic [SRC_W-1:0]     io_c_bits_source = '0;
    logic [35:0]          io_c_bits_address = '0;
    logic                 io_c_bits_echo_blockisdirty = 1'b0;
    logic [BEAT_W-1:0]    io_c_bits_data = '0;
    logic                 io_d_valid;
    logic                 io_d_ready = 1'b1;
    logic [2:0]           io_d_bits_opcode;
    logic [SRC_W-1:0]     io_d_bits_source;
    logic                 io_wb_valid;
    logic                 io_wb_ready = 1'b1;
    logic [35:0]          io_wb_bits_addr;
    logic [2:0]           io_wb_bits_param;
    logic                 io_wb_bits_hasData;
    logic                 io_wb_bits_dirty;
    logic                 io_wb_bits_voluntary;
    logic [2*BEAT_W-1:0]  io_wb_bits_data;

    release_sink #(.SRC_W(SRC_W), .BEAT_W(BEAT_W)) dut (
        .clock                       (clock),
        .reset                       (reset),
        .io_c_valid                  (io_c_valid),
        .io_c_ready                  (io_c_ready),
        .io_c_bits_opcode            (io_c_bits_opcode),
        .io_c_bits_param             (io_c_bits_param),
        .io_c_bits_size              (io_c_bits_size),
        .io_c_bits_source            (io_c_bits_source),
        .io_c_bits_address           (io_c_bits_address),
        .io_c_bits_echo_blockisdirty (io_c_bits_echo_blockisdirty),
        .io_c_bits_data              (io_c_bits_data),
        .io_d_valid                  (io_d_valid),
        .io_d_ready                  (io_d_ready),
        .io_d_bits_opcode            (io_d_bits_opcode),
        .io_d_bits_source            (io_d_bits_source),
        .io_wb_valid                 (io_wb_valid),
        .io_wb_ready                 (io_wb_ready),
        .io_wb_bits_addr             (io_wb_bits_addr),
        .io_wb_bits_param            (io_wb_bits_param),
        .io_wb_bits_hasData          (io_wb_bits_hasData),
        .io_wb_bits_dirty            (io_wb_bits_dirty),
        .io_wb_bits_voluntary        (io_wb_bits_voluntary),
        .io_wb_bits_data             (io_wb_bits_data)
    );

    typedef struct packed {
        logic [35:0]         addr;
        logic [2:0]          param;
        logic                has_data;
        logic                dirty;
        logic                vol;
        logic [2*BEAT_W-1:0] data;
    } wb_t;

    wb_t              wb_q[$];
    logic [SRC_W-1:0] d_q[$];
    int               total = 0;
    int               bad = 0;
    int               last_wait = 0;

    bit rdy_rand = 1'b0;
    bit wb_rdy_man = 1'b1;
    bit d_rdy_man = 1'b1;

    task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [BEAT_W-1:0] rnd_beat();
        logic [BEAT_W-1:0] r;
        for (int k = 0; k < BEAT_W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    always @(posedge clock) begin
        #2;
        if (rdy_rand) begin
            io_wb_ready = ($urandom_range(0, 2) != 0);
            io_d_ready  = ($urandom_range(0, 2) != 0);
        end else begin
            io_wb_ready = wb_rdy_man;
            io_d_ready  = d_rdy_man;
        end
    end

    // Monitor: handshake ordering, stall stability, and scoreboard pops.
    wb_t              cur_wb, exp_wb, prev_wb;
    logic [SRC_W-1:0] exp_src, prev_src;
    logic             wb_hold = 1'b0;
    logic             d_hold = 1'b0;

    always @(negedge clock) begin
        cur_wb = {io_wb_bits_addr, io_wb_bits_param, io_wb_bits_hasData,
                  io_wb_bits_dirty, io_wb_bits_voluntary, io_wb_bits_data};
        if (reset) begin
            wb_hold = 1'b0;
            d_hold  = 1'b0;
        end else begin
            chk("c_rdy_only_when_idle", 640'(io_c_ready), 640'(!(io_wb_valid || io_d_valid)));
            chk("wb_d_overlap", 640'(io_wb_valid && io_d_valid), 640'(0));
            if (wb_hold) begin
                chk("wb_hold_vld", 640'(io_wb_valid), 640'(1));
                chk("wb_hold_bits", 640'(cur_wb), 640'(prev_wb));
            end
            if (d_hold) begin
                chk("d_hold_vld", 640'(io_d_valid), 640'(1));
                chk("d_hold_src", 640'(io_d_bits_source), 640'(prev_src));
            end
            wb_hold  = io_wb_valid && !io_wb_ready;
            prev_wb  = cur_wb;
            d_hold   = io_d_valid && !io_d_ready;
            prev_src = io_d_bits_source;
            if (io_wb_valid && io_wb_ready) begin
                if (wb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wb_unexpected: got wb addr %0h want no wb", io_wb_bits_addr);
                end else begin
                    exp_wb = wb_q.pop_front();
                    chk("wb_bits", 640'(cur_wb), 640'(exp_wb));
                end
            end
            if (io_d_valid && io_d_ready) begin
                if (d_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL d_unexpected: got d source %0h want no d", io_d_bits_source);
                end else begin
                    exp_src = d_q.pop_front();
                    chk("d_source", 640'(io_d_bits_source), 640'(exp_src));
                    chk("d_opcode", 640'(io_d_bits_opcode), 640'(6));
                end
            end
        end
    end

    task automatic send_beat(input logic [2:0] op, input logic [2:0] prm, input logic [SRC_W-1:0] s,
                             input logic [35:0] a, input logic d, input logic [BEAT_W-1:0] dat);
        int i;
        io_c_valid = 1'b1;
        io_c_bits_opcode = op;
        io_c_bits_param = prm;
        io_c_bits_size = 3'd6;
        io_c_bits_source = s;
        io_c_bits_address = a;
        io_c_bits_echo_blockisdirty = d;
        io_c_bits_data = dat;
        for (i = 0; i < 200; i++) begin
            if (io_c_ready) break;
            @(negedge clock);
        end
        last_wait = i;
        if (i == 200) begin
            total++;
            bad++;
            $display("FAIL c_accept_timeout: got no c_ready want c_ready within 200 cycles");
            io_c_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            io_c_valid = 1'b0;
        end
    endtask

    // Reference model: a message with opcode bit2 set yields one writeback; bit1 adds a ReleaseAck.
    task automatic send_txn(input logic [2:0] op, input logic [2:0] prm, input logic [SRC_W-1:0] s,
                            input logic [35:0] a, input logic d, input logic [BEAT_W-1:0] b0,
                            input logic [BEAT_W-1:0] b1, input bit push_d);
        wb_t e;
        if (op >= 3'd4) begin
            e.addr = a;
            e.param = prm;
            e.has_data = (op == 3'd5 || op == 3'd7);
            e.dirty = d;
            e.vol = (op == 3'd6 || op == 3'd7);
            e.data = e.has_data ? {b1, b0} : '0;
            wb_q.push_back(e);
            if (e.vol && push_d) d_q.push_back(s);
        end
        send_beat(op, prm, s, a, d, b0);
        if (op == 3'd5 || op == 3'd7)
            send_beat(3'($urandom_range(0, 7)), 3'($urandom), SRC_W'($urandom), 36'($urandom), !d, b1);
    endtask

    task automatic wait_flag(input bit want_wb, input bit lvl, input string nm);
        int i;
        for (i = 0; i < 50; i++) begin
            @(negedge clock);
            if ((want_wb ? io_wb_valid : io_d_valid) == lvl) break;
        end
        if (i == 50) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no change want valid=%0d within 50 cycles", nm, lvl);
        end
    endtask

    logic [BEAT_W-1:0] aa, ff55;

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_c_rdy", 640'(io_c_ready), 640'(1));
        chk("rst_wb_vld", 640'(io_wb_valid), 640'(0));
        chk("rst_d_vld", 640'(io_d_valid), 640'(0));

        // Dataless Release, all readies high.
        send_txn(3'd6, 3'd1, 2'd0, 36'h0_8000_1000, 1'b0, rnd_beat(), rnd_beat(), 1'b1);
        @(negedge clock);
        chk("rel_lat_wb", 640'(io_wb_valid), 640'(1));
        @(negedge clock);
        chk("rel_lat_d", 640'(io_d_valid), 640'(1));
        @(negedge clock);
        chk("rel_back_idle", 640'(io_c_ready), 640'(1));

        // ReleaseData with alternating-pattern beats.
        for (int k = 0; k < BEAT_W / 8; k++) begin
            aa[k*8 +: 8] = 8'hAA;
            ff55[k*8 +: 8] = 8'h55;
        end
        send_txn(3'd7, 3'd2, 2'd1, 36'h0_8000_2040, 1'b1, aa, ff55, 1'b1);
        @(negedge clock);
        chk("reldata_lat_wb", 640'(io_wb_valid), 640'(1));
        @(negedge clock);
        chk("reldata_lat_d", 640'(io_d_valid), 640'(1));

        // ProbeAckData: no D beat, next C accepted right after wb fire.
        send_txn(3'd5, 3'd0, 2'd2, 36'h1_2345_6780, 1'b1, rnd_beat(), rnd_beat(), 1'b1);
        @(negedge clock);
        chk("probe_wb_vld", 640'(io_wb_valid), 640'(1));
        @(negedge clock);
        chk("probe_no_d", 640'(io_d_valid), 640'(0));
        chk("probe_c_rdy", 640'(io_c_ready), 640'(1));
        send_txn(3'd4, 3'd3, 2'd3, 36'h0_0000_0040, 1'b0, rnd_beat(), rnd_beat(), 1'b1);
        chk("probe_next_wait", 640'(last_wait), 640'(0));
        repeat (3) @(negedge clock);

        // Back-pressure on wb, then on D.
        wb_rdy_man = 1'b0;
        send_txn(3'd7, 3'd1, 2'd3, 36'h0_8000_3000, 1'b1, rnd_beat(), rnd_beat(), 1'b1);
        repeat (10) begin
            @(negedge clock);
            chk("stall_wb_vld", 640'(io_wb_valid), 640'(1));
            chk("stall_wb_c_rdy", 640'(io_c_ready), 640'(0));
        end
        wb_rdy_man = 1'b1;
        d_rdy_man = 1'b0;
        wait_flag(1'b0, 1'b1, "stall_d_rise");
        repeat (5) begin
            @(negedge clock);
            chk("stall_d_vld", 640'(io_d_valid), 640'(1));
            chk("stall_d_c_rdy", 640'(io_c_ready), 640'(0));
        end
        d_rdy_man = 1'b1;
        wait_flag(1'b0, 1'b0, "stall_d_fall");
        chk("stall_d_done_c_rdy", 640'(io_c_ready), 640'(1));

        // Reset while in BEAT1, WB and ACK: nothing further may be emitted.
        for (int s = 0; s < 3; s++) begin
            wb_rdy_man = (s != 1);
            d_rdy_man = (s != 2);
            if (s == 0) send_beat(3'd7, 3'd1, 2'd1, 36'h0_0000_5000, 1'b1, rnd_beat());
            if (s == 1) send_beat(3'd6, 3'd1, 2'd1, 36'h0_0000_6000, 1'b0, rnd_beat());
            if (s == 2) begin
                send_txn(3'd6, 3'd2, 2'd2, 36'h0_0000_7000, 1'b0, rnd_beat(), rnd_beat(), 1'b0);
                wait_flag(1'b0, 1'b1, "rst_ack_rise");
            end
            repeat (2) @(negedge clock);
            @(posedge clock);
            #1 reset = 1'b1;
            @(posedge clock);
            #1 reset = 1'b0;
            @(negedge clock);
            chk("midrst_c_rdy", 640'(io_c_ready), 640'(1));
            chk("midrst_wb_vld", 640'(io_wb_valid), 640'(0));
            chk("midrst_d_vld", 640'(io_d_valid), 640'(0));
            wb_rdy_man = 1'b1;
            d_rdy_man = 1'b1;
            repeat (5) @(negedge clock);
        end

        // Non-release opcode is swallowed in IDLE.
        send_beat(3'd0, 3'd0, 2'd1, 36'h0_0000_8000, 1'b0, rnd_beat());
        chk("op0_accepted", 640'(last_wait), 640'(0));
        @(negedge clock);
        chk("op0_c_rdy", 640'(io_c_ready), 640'(1));
        chk("op0_no_wb", 640'(io_wb_valid), 640'(0));
        repeat (4) @(negedge clock);

        // Randomized traffic with random readies.
        rdy_rand = 1'b1;
        for (int n = 0; n < 60; n++) begin
            send_txn(3'($urandom_range(0, 7)), 3'($urandom), SRC_W'($urandom),
                     {4'($urandom), 32'($urandom)}, 1'($urandom), rnd_beat(), rnd_beat(), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (wb_q.size() == 0 && d_q.size() == 0) break;
        end
        chk("drain_wb_q", 640'(wb_q.size()), 640'(0));
        chk("drain_d_q", 640'(d_q.size()), 640'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/release_sink.md
RELEASE_SINK -- requirements
Module: release_sink

Interface
REQ-001 SHALL have parameter SRC_W, default 2, meaning width of the TileLink source ID.
REQ-002 SHALL have parameter BEAT_W, default 256, meaning channel data beat width; line size is 2*BEAT_W, i.e. 2 beats per line.
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have C-channel input ports: io_c_valid in 1; io_c_ready out 1; io_c_bits_opcode in 3; io_c_bits_param in 3; io_c_bits_size in 3; io_c_bits_source in SRC_W; io_c_bits_address in 36; io_c_bits_echo_blockisdirty in 1; io_c_bits_data in BEAT_W.
REQ-006 SHALL have D-channel output ports: io_d_valid out 1; io_d_ready in 1; io_d_bits_opcode out 3; io_d_bits_source out SRC_W.
REQ-007 SHALL have writeback output ports: io_wb_valid out 1; io_wb_ready in 1; io_wb_bits_addr out 36; io_wb_bits_param out 3; io_wb_bits_hasData out 1; io_wb_bits_dirty out 1; io_wb_bits_voluntary out 1; io_wb_bits_data out 2*BEAT_W.

Function
REQ-008 SHALL implement states IDLE, BEAT1, WB, ACK, one active transaction at a time.
REQ-009 SHALL drive io_c_ready=1 only in IDLE and BEAT1.
REQ-010 SHALL decode C opcodes as follows: 4 ProbeAck; 5 ProbeAckData; 6 Release; 7 ReleaseData. Opcodes 5 and 7 carry data.
REQ-011 On a C fire in IDLE, SHALL latch address, param, source, and echo_blockisdirty into the dirty flag; SHALL set voluntary=(opcode[1]) and hasData=(opcode[0]).
REQ-012 On a C fire in IDLE, SHALL store data in line bits [BEAT_W-1:0] when hasData, and go to BEAT1; otherwise SHALL go to WB.
REQ-013 On a C fire in BEAT1, SHALL store data in line bits [2*BEAT_W-1:BEAT_W] and go to WB; opcode, source and address of beat 1 are ignored.
REQ-014 SHALL accept C opcodes 0-3 in IDLE with io_c_ready=1 and discard them without any state change.
REQ-015 In WB, SHALL hold io_wb_valid=1 with stable bits until io_wb_ready; on fire, SHALL go to ACK if voluntary, else to IDLE.
REQ-016 SHALL force io_wb_bits_data to zero for transactions without data.
REQ-017 In ACK, SHALL hold io_d_valid=1, io_d_bits_opcode=6 (ReleaseAck) and io_d_bits_source=the latched source until io_d_ready; on fire, SHALL go to IDLE.
REQ-018 Latency, with all readies high: SHALL raise io_wb_valid the cycle after the last C beat fires, and io_d_valid the cycle after the wb fire.
REQ-019 Consecutive transactions: SHALL accept a new C beat the cycle after returning to IDLE; no C/D overlap, no bypass.
REQ-020 Back-pressure: io_wb_ready or io_d_ready held low SHALL stall in WB or ACK indefinitely with outputs stable and io_c_ready=0.

Reset
REQ-021 Reset SHALL force state to IDLE and deassert io_wb_valid and io_d_valid; io_c_ready SHALL be 1 in the first cycle after reset.
REQ-022 Reset mid-transaction, in any state, SHALL discard the buffered line without emitting a writeback or ReleaseAck.
REQ-023 Datapath registers (line buffer, address, param) SHALL not be reset.

Structure
REQ-024 TileLink C/D opcode constants and the state enum SHALL live in a shared TL constants package, reused by the release initiator.
REQ-025 The design SHALL be a single module; the 2-beat line buffer SHALL be inline registers with no sub-module.

Verification
REQ-026 Release (op 6, param 1, source 0, address 0x80001000), all readies high -> io_wb_valid the next cycle with hasData=0, voluntary=1 and data 0; ReleaseAck (op 6, source 0) the cycle after.
REQ-027 ReleaseData with beats 0xAA..AA then 0x55..55, dirty=1 -> wb data {0x55..55, 0xAA..AA}, dirty=1, then one ReleaseAck.
REQ-028 ProbeAckData (op 5, source 2) -> wb with voluntary=0 and no D beat; the next C beat is accepted immediately after the wb fire.
REQ-029 ReleaseData with io_wb_ready held 0 for 10 cycles -> io_c_ready=0 and wb bits stable throughout; then io_d_ready=0 for 5 cycles -> io_d_valid held until fire.
REQ-030 Reset asserted in BEAT1 after the first ReleaseData beat -> no wb and no D; state IDLE and io_c_ready=1 the cycle after reset.
REQ-031 C opcode 0 in IDLE -> consumed with io_c_ready=1 and no wb or D activity.
